demod_cal_scheduler: RTL and testbench

DEMOD_CAL_SCHEDULER -- requirements
Module: demod_cal_scheduler

---
 rtl/demod_cal_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_demod_cal_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_cal_scheduler.sv
// Carrier-phase calibration scheduler: sweeps every phase, accumulates |product|
// per phase, and applies the phase with the largest accumulated metric.
module demod_cal_scheduler #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PHASE_W      = 4,
    parameter int unsigned CAL_LEN      = 64,
    parameter int unsigned SETTLE       = 4,
    parameter int unsigned CAL_INTERVAL = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    input  logic                               s_last,
    output logic                               s_ready,
    output logic                               dm_valid,
    input  logic                               dm_ready,
    input  logic                               dm_out_valid,
    input  logic signed [DATA_W-1:0]           dm_out_data,
    input  logic                               dm_out_last,
    output logic                               dm_out_ready,
    output logic                               m_valid,
    input  logic                               m_ready,
    input  logic                               cal_req,
    output logic [PHASE_W-1:0]                 phase_sel,
    output logic                               cal_busy,
    output logic                               cal_done,
    output logic [DATA_W+$clog2(CAL_LEN)-1:0]  best_metric
);

    localparam int unsigned NUM_PH  = 1 << PHASE_W;
    localparam int unsigned ACC_W   = DATA_W + $clog2(CAL_LEN);
    localparam int unsigned CNT_MAX = (CAL_LEN > SETTLE) ? CAL_LEN : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PKT_W   = $clog2(CAL_INTERVAL + 2);

    typedef enum logic [2:0] {
        RUN,
        CAL_SET,
        CAL_SETTLE,
        CAL_ACC,
        CAL_CMP,
        CAL_APPLY
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PHASE_W-1:0]   idx_q;
    logic [PHASE_W-1:0]   best_idx_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     best_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [PKT_W-1:0]     pkt_cnt_q;
    logic                 pending_q;
    logic                 in_pkt_s_q;
    logic                 in_pkt_m_q;

    logic                 hold_c;
    logic                 s_hs_c;
    logic                 o_hs_c;
    logic                 pkt_inc_c;
    logic                 pkt_hit_c;
    logic [DATA_W-1:0]    prod_bits_c;
    logic [DATA_W-1:0]    prod_abs_c;

    // Magnitude as unsigned so the most-negative product maps to 2^(DATA_W-1).
    assign prod_bits_c = dm_out_data;
    assign prod_abs_c  = prod_bits_c[DATA_W-1] ? (~prod_bits_c + DATA_W'(1)) : prod_bits_c;

    assign hold_c    = pending_q & ~in_pkt_s_q;
    assign s_hs_c    = s_valid & s_ready;
    assign o_hs_c    = dm_out_valid & dm_out_ready;
    assign pkt_inc_c = (CAL_INTERVAL != 0) && o_hs_c && dm_out_last
                       && (pkt_cnt_q != PKT_W'(CAL_INTERVAL));
    assign pkt_hit_c = pkt_inc_c && (pkt_cnt_q == PKT_W'(CAL_INTERVAL - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAL_SET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stream steering
    always_comb begin
        state_d      = state_q;
        s_ready      = dm_ready;
        dm_valid     = s_valid;
        m_valid      = 1'b0;
        dm_out_ready = 1'b1;
        cal_busy     = 1'b1;
        cal_done     = 1'b0;
        case (state_q)
            RUN: begin
                s_ready      = dm_ready & ~hold_c;
                dm_valid     = s_valid & ~hold_c;
                m_valid      = dm_out_valid;
                dm_out_ready = m_ready;
                cal_busy     = 1'b0;
                if (pending_q && !in_pkt_s_q && !in_pkt_m_q && !dm_out_valid) begin
                    state_d = CAL_SET;
                end
            end
            CAL_SET: begin
                state_d = (SETTLE == 0) ? CAL_ACC : CAL_SETTLE;
            end
            CAL_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = CAL_ACC;
                end
            end
            CAL_ACC: begin
                if (dm_out_valid && (cnt_q == CNT_W'(CAL_LEN - 1))) begin
                    state_d = CAL_CMP;
                end
            end
            CAL_CMP: begin
                state_d = (idx_q == PHASE_W'(NUM_PH - 1)) ? CAL_APPLY : CAL_SET;
            end
            CAL_APPLY: begin
                cal_done = 1'b1;
                state_d  = RUN;
            end
            default: begin
                state_d = CAL_SET;
            end
        endcase
    end

    // Packet tracking, sweep datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            best_idx_q  <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            cnt_q       <= '0;
            pkt_cnt_q   <= '0;
            pending_q   <= 1'b0;
            in_pkt_s_q  <= 1'b0;
            in_pkt_m_q  <= 1'b0;
            phase_sel   <= '0;
            best_metric <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (s_hs_c) begin
                        in_pkt_s_q <= ~s_last;
                    end
                    if (o_hs_c) begin
                        in_pkt_m_q <= ~dm_out_last;
                    end
                    if (state_d == CAL_SET) begin
                        pending_q <= 1'b0;
                        pkt_cnt_q <= '0;
                        idx_q     <= '0;
                    end else begin
                        if (pkt_inc_c) begin
                            pkt_cnt_q <= pkt_cnt_q + PKT_W'(1);
                        end
                        if (cal_req || pkt_hit_c) begin
                            pending_q <= 1'b1;
                        end
                    end
                end
                CAL_SET: begin
                    phase_sel <= idx_q;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                end
                CAL_SETTLE: begin
                    cnt_q <= (state_d == CAL_ACC) ? '0 : cnt_q + CNT_W'(1);
                end
                CAL_ACC: begin
                    if (dm_out_valid) begin
                        acc_q <= acc_q + ACC_W'(prod_abs_c);
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CAL_CMP: begin
                    // Strict compare so ties keep the lower phase index.
                    if ((idx_q == '0) || (acc_q > best_q)) begin
                        best_q     <= acc_q;
                        best_idx_q <= idx_q;
                    end
                    if (idx_q != PHASE_W'(NUM_PH - 1)) begin
                        idx_q <= idx_q + PHASE_W'(1);
                    end
                end
                CAL_APPLY: begin
                    phase_sel   <= best_idx_q;
                    best_metric <= best_q;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demod_cal_scheduler.sv
// Directed bench for demod_cal_scheduler: phase sweeps with a phase-dependent
// product model, periodic/requested triggers, packet boundaries and reset abort.
module tb_demod_cal_scheduler;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PHASE_W = 4;
    localparam int unsigned MET_W   = DATA_W + 6;

    logic                     clk;
    logic                     rst;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic                     dm_valid;
    logic                     dm_ready;
    logic                     dm_out_valid;
    logic signed [DATA_W-1:0] dm_out_data;
    logic                     dm_out_last;
    logic                     dm_out_ready;
    logic                     m_valid;
    logic                     m_ready;
    logic                     cal_req;
    logic [PHASE_W-1:0]       phase_sel;
    logic                     cal_busy;
    logic                     cal_done;
    logic [MET_W-1:0]         best_metric;

    int                       n_chk;
    int                       n_fail;
    int                       win_idx;
    logic signed [DATA_W-1:0] win_val;
    logic signed [DATA_W-1:0] lose_val;

    demod_cal_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .dm_valid     (dm_valid),
        .dm_ready     (dm_ready),
        .dm_out_valid (dm_out_valid),
        .dm_out_data  (dm_out_data),
        .dm_out_last  (dm_out_last),
        .dm_out_ready (dm_out_ready),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .cal_req      (cal_req),
        .phase_sel    (phase_sel),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .best_metric  (best_metric)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Demodulator product model: one winning phase, odd losing phases negative.
    always_comb begin
        if (int'(phase_sel) == win_idx) dm_out_data = win_val;
        else if (phase_sel[0])          dm_out_data = -lose_val;
        else                            dm_out_data = lose_val;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Feed products until cal_done; lat = clock edges from the call to the cal_done cycle.
    task automatic run_cal(input int max_cyc, input bit gap, input int req_at,
                           output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            dm_out_valid = gap ? i[0] : 1'b1;
            cal_req      = (i == req_at);
            if (cal_done) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        dm_out_valid = 1'b0;
        cal_req      = 1'b0;
    endtask

    task automatic pulse_req(input string tag);
        cal_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cal_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(tag, cal_busy, 1);
    endtask

    task automatic check_result(input string tag, input int lat, input bit ok,
                                input bit chk_lat, input int exp_ph,
                                input logic [63:0] exp_met);
        chk({tag, "_completed"}, ok, 1);
        if (chk_lat) chk({tag, "_latency"}, lat + 1, 1121);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_phase"}, phase_sel, exp_ph);
        chk({tag, "_metric"}, best_metric, exp_met);
        chk({tag, "_done_one_cycle"}, cal_done, 0);
        chk({tag, "_busy_clear"}, cal_busy, 0);
    endtask

    initial begin
        int lat;
        bit ok;
        int busy_cnt;
        bit found;
        logic [3:0] pat;

        n_chk = 0; n_fail = 0;
        rst = 1'b1;
        s_valid = 0; s_last = 0; dm_ready = 0; dm_out_valid = 0;
        dm_out_last = 0; m_ready = 0; cal_req = 0;
        win_idx = 5; win_val = 100; lose_val = 10;

        // Reset values, calibration in progress from the start
        repeat (2) @(negedge clk);
        dm_out_valid = 1'b1;
        #1;
        chk("rst_busy", cal_busy, 1);
        chk("rst_done", cal_done, 0);
        chk("rst_phase", phase_sel, 0);
        chk("rst_metric", best_metric, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_out_ready", dm_out_ready, 1);
        rst = 1'b0;
        run_cal(4000, 1'b0, -1, lat, ok);
        check_result("cal_boot", lat, ok, 1'b1, 5, 64'd6400);

        // RUN pass-through (no handshake reaches a clock edge)
        for (int i = 0; i < 4; i++) begin
            pat = 4'(i);
            s_valid = pat[0]; m_ready = pat[0]; dm_ready = pat[1]; dm_out_valid = pat[1];
            #1;
            chk("run_passthru", {s_ready, dm_valid, m_valid, dm_out_ready},
                {pat[1], pat[0], pat[1], pat[0]});
        end
        s_valid = 0; m_ready = 0; dm_ready = 0; dm_out_valid = 0;
        @(negedge clk);

        // Requested calibration, all phases tie; second request during sweep ignored
        win_idx = -1; lose_val = 7;
        pulse_req("req_start");
        run_cal(4000, 1'b0, 5, lat, ok);
        check_result("cal_tie", lat, ok, 1'b1, 0, 64'd448);
        busy_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (cal_busy) busy_cnt++;
        end
        chk("req_no_repeat", busy_cnt, 0);

        // Periodic trigger: 15 packets do not trigger, 16th does once output idles
        m_ready = 1'b1;
        repeat (15) begin
            dm_out_valid = 1'b1; dm_out_last = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        dm_out_valid = 0; dm_out_last = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("per15_idle", cal_busy, 0);
        s_valid = 1; dm_ready = 1;
        #1;
        chk("per15_s_ready", s_ready, 1);
        s_valid = 0;
        dm_out_valid = 1; dm_out_last = 0;
        @(posedge clk);
        @(negedge clk);
        dm_out_last = 1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 0; dm_out_last = 0; dm_out_valid = 1; s_valid = 1;
        #1;
        chk("per16_hold_s_ready", s_ready, 0);
        chk("per16_hold_dm_valid", dm_valid, 0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("per16_wait_out_valid", cal_busy, 0);
        dm_out_valid = 0; s_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("per16_start", cal_busy, 1);
        win_idx = 12; win_val = 100; lose_val = 10;
        run_cal(4000, 1'b0, -1, lat, ok);
        check_result("cal_periodic", lat, ok, 1'b1, 12, 64'd6400);

        // Request in the middle of input and output packets
        s_valid = 1; s_last = 0; dm_ready = 1;
        dm_out_valid = 1; dm_out_last = 0; m_ready = 1; cal_req = 1;
        @(posedge clk);
        @(negedge clk);
        cal_req = 0;
        #1;
        chk("mid_s_ready", s_ready, 1);
        chk("mid_m_valid", m_valid, 1);
        s_last = 1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 0; s_last = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_wait_out_pkt", cal_busy, 0);
        chk("mid_out_passthru", m_valid, 1);
        s_valid = 1;
        #1;
        chk("mid_hold_s_ready", s_ready, 0);
        s_valid = 0; dm_out_last = 1;
        @(posedge clk);
        @(negedge clk);
        dm_out_valid = 0; dm_out_last = 0; m_ready = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_start", cal_busy, 1);
        win_idx = 2;
        run_cal(4000, 1'b0, -1, lat, ok);
        check_result("cal_mid", lat, ok, 1'b1, 2, 64'd6400);

        // Most-negative product with gapped valid: no wrap, gaps not counted
        win_idx = 9; win_val = 32'sh8000_0000; lose_val = 5;
        pulse_req("neg_start");
        run_cal(6000, 1'b1, -1, lat, ok);
        check_result("cal_negmax", lat, ok, 1'b0, 9, 64'd137438953472);

        // Reset during phase 3 accumulation aborts and restarts the sweep
        win_idx = 5; win_val = 100; lose_val = 10;
        pulse_req("abort_start");
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            dm_out_valid = 1'b1;
            if (phase_sel == 4'd3) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_reached_idx3", found, 1);
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_phase", phase_sel, 0);
        chk("abort_metric", best_metric, 0);
        chk("abort_busy", cal_busy, 1);
        chk("abort_done", cal_done, 0);
        chk("abort_m_valid", m_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_cal(4000, 1'b0, -1, lat, ok);
        check_result("cal_restart", lat, ok, 1'b1, 5, 64'd6400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
